// File: rtl/rom_rr_arbiter_if.sv
// Client-side bus of the ROM round-robin arbiter.
// Requesters drive req/req_addr and receive the grant and read-data pulses.
interface rom_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 4,
    parameter int DW    = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;

    // Client side: issues requests, observes grant and returned data
    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Arbiter side: samples requests, produces grant and returned data
    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port.
// Each transaction walks IDLE -> READ -> DATA (3 cycles). The ROM control
// pins decode from the state register and the latched address only, so a
// requester's req never reaches the ROM pins combinationally.
module rom_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    rom_rr_arbiter_if.slave bus,
    output logic          busy,
    output logic          rom_cs,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_out
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]       state_r;
    logic [IW-1:0]    ptr_r;
    logic [IW-1:0]    id_q_r;
    logic [AW-1:0]    addr_q_r;
    logic [N_REQ-1:0] gnt_r;
    logic [N_REQ-1:0] rvalid_r;
    logic [DW-1:0]    rdata_r;

    logic             found_s;
    logic [IW-1:0]    win_s;
    logic [IW-1:0]    idx_s;

    // Pick the first asserted request starting at ptr and wrapping around
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = IW'((int'(ptr_r) + k) % N_REQ);
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Transaction sequencer: grant, ROM read, data capture and return
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            id_q_r   <= '0;
            addr_q_r <= '0;
            gnt_r    <= '0;
            rvalid_r <= '0;
            rdata_r  <= '0;
        end else begin
            gnt_r    <= '0;
            rvalid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        addr_q_r     <= bus.req_addr[win_s*AW +: AW];
                        id_q_r       <= win_s;
                        gnt_r[win_s] <= 1'b1;
                        state_r      <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    // The winner drops to lowest priority for the next round
                    if (id_q_r == IW'(N_REQ - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= id_q_r + 1'b1;
                    end
                    state_r <= DATA;
                end
                DATA: begin
                    rdata_r          <= rom_out;
                    rvalid_r[id_q_r] <= 1'b1;
                    state_r          <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // ROM pins: cs stays high through DATA so the ROM output is held, not X
    always_comb begin
        rom_cs   = 1'b0;
        rom_rd   = 1'b0;
        rom_addr = '0;
        case (state_r)
            READ: begin
                rom_cs   = 1'b1;
                rom_rd   = 1'b1;
                rom_addr = addr_q_r;
            end
            DATA: begin
                rom_cs   = 1'b1;
                rom_rd   = 1'b0;
                rom_addr = addr_q_r;
            end
            default: begin
                rom_cs   = 1'b0;
                rom_rd   = 1'b0;
                rom_addr = '0;
            end
        endcase
    end

    assign busy       = (state_r != IDLE);
    assign bus.gnt    = gnt_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
endmodule
